// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the opcode decoder (CU), the ALU and cpu_sequencer.
//   - OP_*   : 4-bit instruction opcodes (0000..1111; 1100-1110 undefined)
//   - ALU_*  : 4-bit ALU operation codes as produced by CU (0001..1010)
//   - seq_state_e : cpu_sequencer FSM state encoding
//   - op_is_undef / op_is_cmp : opcode classification helpers
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_LT   = 4'hA;
    localparam logic [3:0] OP_EQ   = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] ALU_ADD = 4'h1;
    localparam logic [3:0] ALU_SUB = 4'h2;
    localparam logic [3:0] ALU_AND = 4'h3;
    localparam logic [3:0] ALU_OR  = 4'h4;
    localparam logic [3:0] ALU_XOR = 4'h5;
    localparam logic [3:0] ALU_NOT = 4'h6;
    localparam logic [3:0] ALU_SHL = 4'h7;
    localparam logic [3:0] ALU_SHR = 4'h8;
    localparam logic [3:0] ALU_LT  = 4'h9;
    localparam logic [3:0] ALU_EQ  = 4'hA;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_RD_A,
        S_RD_B,
        S_EXEC,
        S_WB,
        S_HALT
    } seq_state_e;

    function automatic logic op_is_undef(input logic [3:0] op);
        return (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
    endfunction

    function automatic logic op_is_cmp(input logic [3:0] op);
        return (op == OP_LT) || (op == OP_EQ);
    endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle fetch/decode/execute controller. Fetches an instruction over a
// req/ack port, presents its opcode to the external CU, and turns CU's level
// outputs into timed data-RAM read/write strobes and a one-cycle ALU enable.
//
// Optional feature macro: SEQ_SINGLE_STEP_EN
//   defined   -> extra input 'step'; FSM returns to IDLE after every retire,
//                start or step runs one more instruction.
//   undefined -> free-running execution, no 'step' port.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start             leave IDLE and fetch at pc
//   instr_req/addr    fetch request / address (= pc)
//   instr_ack/data    fetch handshake / instruction word
//   opcode            registered opcode to CU
//   cu_*              CU decoded outputs
//   ram_re/we/addr/wdata/rdata   data RAM port (1-cycle read latency)
//   alu_en/op/a/b/result         ALU interface
//   cmp_flag          result of the last LT/EQ
//   instr_done        one-cycle retire pulse
//   illegal           one-cycle pulse on undefined opcode
//   halted, busy      status
// -----------------------------------------------------------------------------
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int ADDR_W  = 4,
    parameter  int PC_W    = 8,
    localparam int INSTR_W = 4 + 2*ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic               step,
`endif
    output logic               instr_req,
    output logic [PC_W-1:0]    instr_addr,
    input  logic               instr_ack,
    input  logic [INSTR_W-1:0] instr_data,
    output logic [3:0]         opcode,
    input  logic               cu_ram_read,
    input  logic               cu_ram_write,
    input  logic               cu_alu_enable,
    input  logic [3:0]         cu_alu_op,
    output logic               ram_re,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic [DATA_W-1:0]  ram_rdata,
    output logic               alu_en,
    output logic [3:0]         alu_op,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               cmp_flag,
    output logic               instr_done,
    output logic               illegal,
    output logic               halted,
    output logic               busy
);

    seq_state_e           r_state;
    seq_state_e           w_next;
    logic [PC_W-1:0]      r_pc;
    logic [INSTR_W-1:0]   r_instr;
    logic                 r_cu_alu_en;
    logic [3:0]           r_alu_op;
    logic [DATA_W-1:0]    r_alu_a;
    logic [DATA_W-1:0]    r_alu_b;
    logic [DATA_W-1:0]    r_result;
    logic                 r_cmp;

    logic [3:0]           w_op;
    logic [ADDR_W-1:0]    w_dst;
    logic [ADDR_W-1:0]    w_src;
    logic                 w_go;
    seq_state_e           w_after;

    assign w_op  = r_instr[INSTR_W-1 -: 4];
    assign w_dst = r_instr[2*ADDR_W-1 -: ADDR_W];
    assign w_src = r_instr[ADDR_W-1:0];

`ifdef SEQ_SINGLE_STEP_EN
    assign w_go    = start | step;
    assign w_after = S_IDLE;
`else
    assign w_go    = start;
    assign w_after = S_FETCH;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_instr     <= '0;
            r_cu_alu_en <= 1'b0;
            r_alu_op    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_result    <= '0;
            r_cmp       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (instr_done) begin
                r_pc <= r_pc + 1'b1;
            end
            case (r_state)
                S_FETCH: if (instr_ack) r_instr <= instr_data;
                S_DECODE: begin
                    r_cu_alu_en <= cu_alu_enable;
                    r_alu_op    <= cu_alu_op;
                end
                // rdata here answers the RD_A read of dst; MOV skips RD_A.
                S_RD_B: if (r_cu_alu_en) r_alu_a <= ram_rdata;
                S_EXEC: begin
                    r_alu_b  <= ram_rdata;
                    r_result <= r_cu_alu_en ? alu_result : ram_rdata;
                    if (r_cu_alu_en && op_is_cmp(w_op)) begin
                        r_cmp <= alu_result[0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next     = r_state;
        instr_req  = 1'b0;
        ram_re     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        alu_en     = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_IDLE: if (w_go) w_next = S_FETCH;
            S_FETCH: begin
                instr_req = 1'b1;
                if (instr_ack) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_op == OP_HALT) begin
                    w_next = S_HALT;
                end else if (w_op == OP_NOP || op_is_undef(w_op)) begin
                    illegal    = op_is_undef(w_op);
                    instr_done = 1'b1;
                    w_next     = w_after;
                end else if (cu_alu_enable) begin
                    w_next = S_RD_A;
                end else if (cu_ram_read || cu_ram_write) begin
                    w_next = S_RD_B;
                end else begin
                    // CU reports no datapath action: retire as a NOP.
                    instr_done = 1'b1;
                    w_next     = w_after;
                end
            end
            S_RD_A: begin
                ram_re   = 1'b1;
                ram_addr = w_dst;
                w_next   = S_RD_B;
            end
            S_RD_B: begin
                ram_re   = 1'b1;
                ram_addr = w_src;
                w_next   = S_EXEC;
            end
            S_EXEC: begin
                alu_en = r_cu_alu_en;
                if (r_cu_alu_en && op_is_cmp(w_op)) begin
                    instr_done = 1'b1;
                    w_next     = w_after;
                end else begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                ram_we     = 1'b1;
                ram_addr   = w_dst;
                instr_done = 1'b1;
                w_next     = w_after;
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    assign instr_addr = r_pc;
    assign opcode     = w_op;
    assign alu_op     = r_alu_op;
    assign alu_a      = r_alu_a;
    // The src word arrives in EXEC; forward it so the ALU sees it that cycle.
    assign alu_b      = (r_state == S_EXEC) ? ram_rdata : r_alu_b;
    assign ram_wdata  = (r_state == S_WB) ? r_result : '0;
    assign cmp_flag   = r_cmp;
    assign halted     = (r_state == S_HALT);
    assign busy       = (r_state != S_IDLE) && (r_state != S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
// Environment models for instruction memory, CU, data RAM and ALU around
// cpu_sequencer; expected ALU/write/illegal/retire events are queued by the
// stimulus and consumed by an independent monitor.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        instr_req, instr_ack;
    logic [7:0]  instr_addr;
    logic [11:0] instr_data;
    logic [3:0]  opcode;
    logic        cu_ram_read, cu_ram_write, cu_alu_enable;
    logic [3:0]  cu_alu_op;
    logic        ram_re, ram_we;
    logic [3:0]  ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
    logic        alu_en;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic        cmp_flag, instr_done, illegal, halted, busy;

    always #5 clk = ~clk;

    cpu_sequencer #(.DATA_W(8), .ADDR_W(4), .PC_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef SEQ_SINGLE_STEP_EN
        .step(1'b0),
`endif
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_ack(instr_ack), .instr_data(instr_data),
        .opcode(opcode),
        .cu_ram_read(cu_ram_read), .cu_ram_write(cu_ram_write),
        .cu_alu_enable(cu_alu_enable), .cu_alu_op(cu_alu_op),
        .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result),
        .cmp_flag(cmp_flag), .instr_done(instr_done), .illegal(illegal),
        .halted(halted), .busy(busy)
    );

    // ---------------- environment models ----------------
    logic [11:0] imem [0:15];
    logic [7:0]  mem  [0:15];
    int          ack_delay;
    int          wait_cnt;

    always_comb begin
        cu_ram_read = 1'b0; cu_ram_write = 1'b0; cu_alu_enable = 1'b0; cu_alu_op = 4'h0;
        if (opcode == OP_MOV) begin
            cu_ram_read = 1'b1; cu_ram_write = 1'b1;
        end else if (opcode >= OP_ADD && opcode <= OP_EQ) begin
            cu_ram_read   = 1'b1;
            cu_alu_enable = 1'b1;
            cu_alu_op     = opcode - 4'd1;
            cu_ram_write  = !(opcode == OP_LT || opcode == OP_EQ);
        end
    end

    always_comb begin
        case (alu_op)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_LT:  alu_result = {7'b0, alu_a < alu_b};
            ALU_EQ:  alu_result = {7'b0, alu_a == alu_b};
            default: alu_result = 8'h00;
        endcase
    end

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
    end

    // Instruction memory responder: ack after ack_delay waiting cycles.
    initial begin
        instr_ack = 1'b0; instr_data = 12'h000; wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                instr_ack = 1'b0; wait_cnt = 0;
            end else if (instr_req && !instr_ack) begin
                if (wait_cnt >= ack_delay) begin
                    instr_ack  = 1'b1;
                    instr_data = imem[instr_addr[3:0]];
                    wait_cnt   = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                instr_ack = 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    localparam logic [1:0] K_DONE = 2'd0, K_ALU = 2'd1, K_WR = 2'd2, K_ILL = 2'd3;
    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] v0;
        logic [7:0] v1;
        logic [3:0] v2;
    } ev_t;

    ev_t sb[$];
    int  n_pass = 0;
    int  n_total = 0;
    bit  overlap = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic void push_ev(input logic [1:0] k, input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
        ev_t e;
        e.kind = k; e.v0 = a; e.v1 = b; e.v2 = c;
        sb.push_back(e);
    endfunction

    function automatic void pop_cmp(input string name, input ev_t act);
        ev_t e;
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_%s: got %0h expected no event", name, act);
        end else begin
            e = sb.pop_front();
            check(name, 64'(act), 64'(e));
        end
    endfunction

    always @(negedge clk) begin
        if (alu_en)     pop_cmp("alu_event",  {K_ALU,  alu_a, alu_b, alu_op});
        if (ram_we)     pop_cmp("ram_write",  {K_WR,   4'h0, ram_addr, ram_wdata, 4'h0});
        if (illegal)    pop_cmp("illegal",    {K_ILL,  instr_addr, 8'h00, 4'h0});
        if (instr_done) pop_cmp("instr_done", {K_DONE, instr_addr, 8'h00, 4'h0});
        if (ram_re && ram_we) overlap = 1'b1;
    end

    // ---------------- stimulus ----------------
    function automatic logic [63:0] out_vec();
        return {instr_req, instr_addr, opcode, ram_re, ram_we, ram_addr, ram_wdata,
                alu_en, alu_op, alu_a, alu_b, cmp_flag, instr_done, illegal, halted, busy};
    endfunction

    // Cycles from first FETCH cycle to the retire pulse, inclusive.
    task automatic measure(output int cyc, output logic [7:0] faddr, output int reqc,
                           output bit stable, output bit ramact);
        bit seen = 1'b0;
        int n = 0;
        cyc = -1; faddr = 8'hFF; reqc = 0; stable = 1'b1; ramact = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (instr_req && !seen) begin
                seen = 1'b1; faddr = instr_addr;
            end
            if (seen) begin
                n++;
                if (instr_req) begin
                    reqc++;
                    if (instr_addr !== faddr) stable = 1'b0;
                end
                if (ram_re || ram_we) ramact = 1'b1;
                if (instr_done) begin
                    cyc = n;
                    break;
                end
            end
        end
    endtask

    initial begin
        int         cyc, reqc;
        logic [7:0] fa;
        bit         stb, ra, found;

        rst = 1'b1; start = 1'b0; ack_delay = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            imem[i] = 12'hF00;
            mem[i]  = 8'h00;
        end
        imem[0] = 12'h235; imem[1] = 12'h124; imem[2] = 12'hB11;
        imem[3] = 12'hC00; imem[4] = 12'hF00;
        mem[3] = 8'h07; mem[5] = 8'h09; mem[4] = 8'hA5; mem[1] = 8'h3C;

        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 64'h0);
        rst = 1'b0;

        push_ev(K_ALU, 8'h07, 8'h09, ALU_ADD);
        push_ev(K_WR, 8'h03, 8'h10, 4'h0);
        push_ev(K_DONE, 8'h00, 8'h00, 4'h0);
        push_ev(K_WR, 8'h02, 8'hA5, 4'h0);
        push_ev(K_DONE, 8'h01, 8'h00, 4'h0);
        push_ev(K_ALU, 8'h3C, 8'h3C, ALU_EQ);
        push_ev(K_DONE, 8'h02, 8'h00, 4'h0);
        push_ev(K_ILL, 8'h03, 8'h00, 4'h0);
        push_ev(K_DONE, 8'h03, 8'h00, 4'h0);

        start = 1'b1;
        measure(cyc, fa, reqc, stb, ra);
        check("add_cycles", cyc, 6);
        check("add_fetch_pc", fa, 8'h00);
        measure(cyc, fa, reqc, stb, ra);
        check("mov_cycles", cyc, 5);
        check("mov_fetch_pc", fa, 8'h01);
        measure(cyc, fa, reqc, stb, ra);
        check("eq_cycles", cyc, 5);
        check("eq_fetch_pc", fa, 8'h02);
        measure(cyc, fa, reqc, stb, ra);
        check("undef_fetch_pc", fa, 8'h03);
        check("cmp_flag", cmp_flag, 1'b1);

        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (halted) begin found = 1'b1; break; end
        end
        check("halted", found, 1'b1);
        check("halt_busy", busy, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("halt_ignores_start", halted, 1'b1);
        check("halt_no_fetch", instr_req, 1'b0);
        check("sb_empty_prog", sb.size(), 0);

        // Delayed acknowledge on a NOP
        rst = 1'b1;
        repeat (2) @(negedge clk);
        imem[0] = 12'h000; imem[1] = 12'hF00; ack_delay = 3;
        push_ev(K_DONE, 8'h00, 8'h00, 4'h0);
        rst = 1'b0; start = 1'b1;
        measure(cyc, fa, reqc, stb, ra);
        check("delay_cycles", cyc, 5);
        check("delay_req_cycles", reqc, 4);
        check("delay_addr_stable", stb, 1'b1);
        check("delay_no_ram", ra, 1'b0);

        // Reset during EXEC of an ADD (mem[3] now holds 16)
        rst = 1'b1;
        repeat (2) @(negedge clk);
        ack_delay = 0; imem[0] = 12'h235;
        push_ev(K_ALU, 8'h10, 8'h09, ALU_ADD);
        rst = 1'b0; start = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (alu_en) begin found = 1'b1; break; end
        end
        check("reach_exec", found, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_exec_outputs", out_vec(), 64'h0);
        check("rst_exec_pc", instr_addr, 8'h00);
        check("rst_exec_no_write", mem[3], 8'h10);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_exec_idle", {busy, halted, instr_req}, 3'b000);
        check("sb_empty_end", sb.size(), 0);
        check("re_we_exclusive", overlap, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
